seq_decoder: RTL and testbench

//  Multi-cycle successor of the combinational Jac1-8 decoder. It latches each instruction from program

---
 rtl/jac_pkg.sv | 55 +++++
 rtl/seq_decoder_branch_cond.sv | 25 ++
 rtl/seq_decoder.sv | 181 ++++++++++++++++++
 tb/tb_seq_decoder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jac_pkg.sv
// Shared definitions for the Jac1-8 sequential decoder: opcode encodings,
// FSM state encoding, ALU status flag indices and opcode classification helpers.
package jac_pkg;

  localparam logic [4:0] Op_NOP  = 5'b00000;
  localparam logic [4:0] Op_ADD  = 5'b00001;
  localparam logic [4:0] Op_SUB  = 5'b00010;
  localparam logic [4:0] Op_AND  = 5'b00011;
  localparam logic [4:0] Op_OR   = 5'b00100;
  localparam logic [4:0] Op_XOR  = 5'b00101;
  localparam logic [4:0] Op_SHL  = 5'b00110;
  localparam logic [4:0] Op_SHR  = 5'b00111;
  localparam logic [4:0] Op_NOT  = 5'b01000;
  localparam logic [4:0] Op_VAL  = 5'b01001;
  localparam logic [4:0] Op_GOTO = 5'b10000;
  localparam logic [4:0] Op_IFZ  = 5'b10001;
  localparam logic [4:0] Op_IFNZ = 5'b10010;
  localparam logic [4:0] Op_IFEQ = 5'b10011;
  localparam logic [4:0] Op_IFST = 5'b10100;
  localparam logic [4:0] Op_IFGT = 5'b10101;

  localparam int ST_Z  = 0;
  localparam int ST_LT = 1;
  localparam int ST_GT = 2;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  // Anything outside the sixteen defined encodings traps.
  function automatic logic is_reserved(input logic [4:0] op);
    case (op)
      Op_NOP, Op_ADD, Op_SUB, Op_AND, Op_OR, Op_XOR, Op_SHL, Op_SHR,
      Op_NOT, Op_VAL, Op_GOTO, Op_IFZ, Op_IFNZ, Op_IFEQ, Op_IFST, Op_IFGT:
        is_reserved = 1'b0;
      default:
        is_reserved = 1'b1;
    endcase
  endfunction

  function automatic logic is_alu2(input logic [4:0] op);
    case (op)
      Op_ADD, Op_SUB, Op_AND, Op_OR, Op_XOR, Op_SHL, Op_SHR: is_alu2 = 1'b1;
      default:                                               is_alu2 = 1'b0;
    endcase
  endfunction

  function automatic logic is_write(input logic [4:0] op);
    is_write = is_alu2(op) || (op == Op_NOT) || (op == Op_VAL);
  endfunction

endpackage

// File: rtl/seq_decoder_branch_cond.sv
// Branch resolution: decides from the latched opcode and ALU flags whether the
// PC is loaded with the literal address. GOTO is treated as always taken.
module branch_cond
  import jac_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic [2:0] status,
  output logic       taken
);

  // Flag combination per conditional opcode; non-branches never load the PC.
  always_comb begin
    taken = 1'b0;
    case (opcode)
      Op_GOTO: taken = 1'b1;
      Op_IFZ:  taken = status[ST_Z];
      Op_IFNZ: taken = ~status[ST_Z];
      Op_IFEQ: taken = ~status[ST_LT] & ~status[ST_GT];
      Op_IFST: taken = status[ST_LT];
      Op_IFGT: taken = status[ST_GT];
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/seq_decoder.sv
// Multi-cycle Jac1-8 instruction decoder: FETCH/DECODE/EXEC sequencing with a
// valid/ready instruction handshake, ALU stall support and a sticky trap on reserved opcodes.
module seq_decoder
  import jac_pkg::*;
#(
  parameter int SEL_WIDTH  = 2,
  parameter int PC_WIDTH   = 8,
  parameter int PROG_WIDTH = 16,
  parameter int PARAM_BITS = 8,
  parameter int OP1_MSB    = 9,
  parameter int OP2_MSB    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PROG_WIDTH-1:0] instr,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [2:0]            status,
  input  logic                  alu_busy,
  output logic [4:0]            opcode,
  output logic [PARAM_BITS-1:0] param,
  output logic [PC_WIDTH-1:0]   literal_adr,
  output logic [SEL_WIDTH-1:0]  rd_sel1,
  output logic [SEL_WIDTH-1:0]  rd_sel2,
  output logic                  rd_en1,
  output logic                  rd_en2,
  output logic [SEL_WIDTH-1:0]  wr_sel,
  output logic                  wr_en,
  output logic                  sel_reg_in_alu_decoder,
  output logic                  cnt_wr_en,
  output logic                  pc_inc,
  output logic                  illegal_op
);

  state_t                state_r, state_s;
  logic [PROG_WIDTH-1:0] ir_r, ir_s;
  logic [4:0]            ir_op_s;
  logic [SEL_WIDTH-1:0]  ir_op1_s, ir_op2_s;
  logic [PARAM_BITS-1:0] ir_imm_s;
  logic                  alu2_s, not_s, taken_s, retired_s, unused_ir_s;

  logic                  instr_ready_s, rd_en1_s, rd_en2_s, wr_en_s, sel_s;
  logic                  cnt_wr_en_s, pc_inc_s, illegal_op_s;
  logic [4:0]            opcode_s;
  logic [PARAM_BITS-1:0] param_s;
  logic [PC_WIDTH-1:0]   literal_adr_s;
  logic [SEL_WIDTH-1:0]  rd_sel1_s, rd_sel2_s, wr_sel_s;

  assign ir_op_s     = ir_r[PROG_WIDTH-1 -: 5];
  assign ir_op1_s    = ir_r[OP1_MSB -: SEL_WIDTH];
  assign ir_op2_s    = ir_r[OP2_MSB -: SEL_WIDTH];
  assign ir_imm_s    = ir_r[PARAM_BITS-1:0];
  assign alu2_s      = is_alu2(ir_op_s);
  assign not_s       = (ir_op_s == Op_NOT);
  // The PC strobe of the retire cycle is still visible one cycle later; that marks the way back to FETCH.
  assign retired_s   = cnt_wr_en | pc_inc;
  assign unused_ir_s = ^ir_r;

  branch_cond u_branch_cond (
    .opcode (opcode),
    .status (status),
    .taken  (taken_s)
  );

  // Next-state and next-output logic; every output register holds unless changed below.
  always_comb begin
    state_s       = state_r;
    ir_s          = ir_r;
    instr_ready_s = instr_ready;
    opcode_s      = opcode;
    param_s       = param;
    literal_adr_s = literal_adr;
    rd_sel1_s     = rd_sel1;
    rd_sel2_s     = rd_sel2;
    rd_en1_s      = rd_en1;
    rd_en2_s      = rd_en2;
    wr_sel_s      = wr_sel;
    sel_s         = sel_reg_in_alu_decoder;
    illegal_op_s  = illegal_op;
    wr_en_s       = 1'b0;
    cnt_wr_en_s   = 1'b0;
    pc_inc_s      = 1'b0;
    case (state_r)
      S_FETCH: begin
        instr_ready_s = 1'b1;
        if (instr_valid) begin
          ir_s          = instr;
          instr_ready_s = 1'b0;
          state_s       = S_DECODE;
        end else begin
          state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        if (is_reserved(ir_op_s)) begin
          illegal_op_s = 1'b1;
          state_s      = S_HALT;
        end else begin
          opcode_s      = ir_op_s;
          param_s       = ir_imm_s;
          literal_adr_s = PC_WIDTH'(ir_imm_s);
          rd_sel1_s     = alu2_s ? ir_op1_s : {SEL_WIDTH{1'b0}};
          rd_en1_s      = alu2_s;
          rd_sel2_s     = (alu2_s || not_s) ? ir_op2_s : {SEL_WIDTH{1'b0}};
          rd_en2_s      = alu2_s || not_s;
          wr_sel_s      = is_write(ir_op_s) ? ir_op1_s : {SEL_WIDTH{1'b0}};
          sel_s         = alu2_s || not_s;
          state_s       = S_EXEC;
        end
      end
      S_EXEC: begin
        if (retired_s) begin
          instr_ready_s = 1'b1;
          opcode_s      = 5'b00000;
          param_s       = {PARAM_BITS{1'b0}};
          literal_adr_s = {PC_WIDTH{1'b0}};
          rd_sel1_s     = {SEL_WIDTH{1'b0}};
          rd_sel2_s     = {SEL_WIDTH{1'b0}};
          rd_en1_s      = 1'b0;
          rd_en2_s      = 1'b0;
          wr_sel_s      = {SEL_WIDTH{1'b0}};
          sel_s         = 1'b0;
          state_s       = S_FETCH;
        end else if (alu_busy) begin
          state_s = S_EXEC;
        end else begin
          wr_en_s     = is_write(opcode);
          cnt_wr_en_s = taken_s;
          pc_inc_s    = ~taken_s;
          state_s     = S_EXEC;
        end
      end
      S_HALT: begin
        state_s = S_HALT;
      end
      default: begin
        state_s = S_FETCH;
      end
    endcase
  end

  // State, instruction register and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r                <= S_FETCH;
      ir_r                   <= {PROG_WIDTH{1'b0}};
      instr_ready            <= 1'b1;
      opcode                 <= 5'b00000;
      param                  <= {PARAM_BITS{1'b0}};
      literal_adr            <= {PC_WIDTH{1'b0}};
      rd_sel1                <= {SEL_WIDTH{1'b0}};
      rd_sel2                <= {SEL_WIDTH{1'b0}};
      rd_en1                 <= 1'b0;
      rd_en2                 <= 1'b0;
      wr_sel                 <= {SEL_WIDTH{1'b0}};
      wr_en                  <= 1'b0;
      sel_reg_in_alu_decoder <= 1'b0;
      cnt_wr_en              <= 1'b0;
      pc_inc                 <= 1'b0;
      illegal_op             <= 1'b0;
    end else begin
      state_r                <= state_s;
      ir_r                   <= ir_s;
      instr_ready            <= instr_ready_s;
      opcode                 <= opcode_s;
      param                  <= param_s;
      literal_adr            <= literal_adr_s;
      rd_sel1                <= rd_sel1_s;
      rd_sel2                <= rd_sel2_s;
      rd_en1                 <= rd_en1_s;
      rd_en2                 <= rd_en2_s;
      wr_sel                 <= wr_sel_s;
      wr_en                  <= wr_en_s;
      sel_reg_in_alu_decoder <= sel_s;
      cnt_wr_en              <= cnt_wr_en_s;
      pc_inc                 <= pc_inc_s;
      illegal_op             <= illegal_op_s;
    end
  end

endmodule

// File: tb/tb_seq_decoder.sv
// Self-checking bench for seq_decoder: a transaction-level expectation model
// compared every cycle, plus hand-computed literal checks of key cycles.
module tb_seq_decoder;

  localparam logic [4:0] OP_NOP  = 5'b00000, OP_ADD  = 5'b00001, OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00011, OP_OR   = 5'b00100, OP_XOR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110, OP_SHR  = 5'b00111, OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_VAL  = 5'b01001, OP_GOTO = 5'b10000, OP_IFZ  = 5'b10001;
  localparam logic [4:0] OP_IFNZ = 5'b10010, OP_IFEQ = 5'b10011, OP_IFST = 5'b10100;
  localparam logic [4:0] OP_IFGT = 5'b10101;

  typedef struct packed {
    logic       instr_ready;
    logic [4:0] opcode;
    logic [7:0] param;
    logic [7:0] literal_adr;
    logic [1:0] rd_sel1;
    logic [1:0] rd_sel2;
    logic       rd_en1;
    logic       rd_en2;
    logic [1:0] wr_sel;
    logic       wr_en;
    logic       sel;
    logic       cnt_wr_en;
    logic       pc_inc;
    logic       illegal_op;
  } outs_t;

  logic        clk = 1'b0;
  logic        rst_n, instr_valid, alu_busy;
  logic [15:0] instr;
  logic [2:0]  status;
  logic        instr_ready, rd_en1, rd_en2, wr_en, sel_reg_in_alu_decoder;
  logic        cnt_wr_en, pc_inc, illegal_op;
  logic [4:0]  opcode;
  logic [7:0]  param, literal_adr;
  logic [1:0]  rd_sel1, rd_sel2, wr_sel;

  int    checks = 0;
  int    errors = 0;
  bit    cmp_en = 1'b0;
  outs_t exp_o, snap_dec, snap_ret;

  always #5 clk = ~clk;

  seq_decoder dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .status(status), .alu_busy(alu_busy),
    .opcode(opcode), .param(param), .literal_adr(literal_adr),
    .rd_sel1(rd_sel1), .rd_sel2(rd_sel2), .rd_en1(rd_en1), .rd_en2(rd_en2),
    .wr_sel(wr_sel), .wr_en(wr_en), .sel_reg_in_alu_decoder(sel_reg_in_alu_decoder),
    .cnt_wr_en(cnt_wr_en), .pc_inc(pc_inc), .illegal_op(illegal_op)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [1:0] op1, input logic [7:0] imm);
    mk = {op, 1'b0, op1, imm};
  endfunction

  function automatic outs_t idle_o();
    outs_t o;
    o = '0;
    o.instr_ready = 1'b1;
    return o;
  endfunction

  // Fields that must be visible from the decode cycle until the instruction retires.
  function automatic outs_t dec_model(input logic [15:0] ins);
    outs_t      o;
    logic [4:0] op;
    o  = '0;
    op = ins[15:11];
    o.opcode      = op;
    o.param       = ins[7:0];
    o.literal_adr = ins[7:0];
    if (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR}) begin
      o.rd_sel1 = ins[9:8]; o.rd_en1 = 1'b1;
      o.rd_sel2 = ins[4:3]; o.rd_en2 = 1'b1;
      o.sel = 1'b1; o.wr_sel = ins[9:8];
    end else if (op == OP_NOT) begin
      o.rd_sel2 = ins[4:3]; o.rd_en2 = 1'b1;
      o.sel = 1'b1; o.wr_sel = ins[9:8];
    end else if (op == OP_VAL) begin
      o.wr_sel = ins[9:8];
    end
    return o;
  endfunction

  function automatic logic model_taken(input logic [4:0] op, input logic [2:0] st);
    case (op)
      OP_GOTO: return 1'b1;
      OP_IFZ:  return st[0];
      OP_IFNZ: return !st[0];
      OP_IFEQ: return !st[1] && !st[2];
      OP_IFST: return st[1];
      OP_IFGT: return st[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic outs_t ret_model(input logic [15:0] ins, input logic [2:0] st);
    outs_t      o;
    logic [4:0] op;
    o  = dec_model(ins);
    op = ins[15:11];
    o.wr_en     = (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_NOT, OP_VAL});
    o.cnt_wr_en = model_taken(op, st);
    o.pc_inc    = !model_taken(op, st);
    return o;
  endfunction

  function automatic outs_t dut_o();
    outs_t o;
    o = {instr_ready, opcode, param, literal_adr, rd_sel1, rd_sel2, rd_en1, rd_en2,
         wr_sel, wr_en, sel_reg_in_alu_decoder, cnt_wr_en, pc_inc, illegal_op};
    return o;
  endfunction

  // Every-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_instr_ready", 16'(instr_ready), 16'(exp_o.instr_ready));
      check("cyc_opcode",      16'(opcode),      16'(exp_o.opcode));
      check("cyc_param",       16'(param),       16'(exp_o.param));
      check("cyc_literal_adr", 16'(literal_adr), 16'(exp_o.literal_adr));
      check("cyc_rd_sel1",     16'(rd_sel1),     16'(exp_o.rd_sel1));
      check("cyc_rd_sel2",     16'(rd_sel2),     16'(exp_o.rd_sel2));
      check("cyc_rd_en1",      16'(rd_en1),      16'(exp_o.rd_en1));
      check("cyc_rd_en2",      16'(rd_en2),      16'(exp_o.rd_en2));
      check("cyc_wr_sel",      16'(wr_sel),      16'(exp_o.wr_sel));
      check("cyc_wr_en",       16'(wr_en),       16'(exp_o.wr_en));
      check("cyc_sel_alu_dec", 16'(sel_reg_in_alu_decoder), 16'(exp_o.sel));
      check("cyc_cnt_wr_en",   16'(cnt_wr_en),   16'(exp_o.cnt_wr_en));
      check("cyc_pc_inc",      16'(pc_inc),      16'(exp_o.pc_inc));
      check("cyc_illegal_op",  16'(illegal_op),  16'(exp_o.illegal_op));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full instruction: handshake, decode, optional stall, retire, return to fetch.
  task automatic run_instr(input logic [15:0] ins, input int busy,
                           input logic [2:0] st_stall, input logic [2:0] st_ret);
    instr = ins; instr_valid = 1'b1;
    step(); exp_o = '0;
    instr_valid = 1'b0; instr = 16'hFFFF;
    step(); exp_o = dec_model(ins); snap_dec = dut_o();
    for (int i = 0; i < busy; i++) begin
      alu_busy = 1'b1;
      status   = (i % 2 == 0) ? st_stall : ~st_stall;
      step();
    end
    alu_busy = 1'b0; status = st_ret;
    step(); exp_o = ret_model(ins, st_ret); snap_ret = dut_o();
    status = ~st_ret;
    step(); exp_o = idle_o();
  endtask

  logic [4:0] alu_ops [5] = '{OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR};
  logic [4:0] br_op   [8] = '{OP_IFNZ, OP_IFNZ, OP_IFEQ, OP_IFEQ, OP_IFST, OP_IFST, OP_IFGT, OP_IFGT};
  logic [2:0] br_st   [8] = '{3'b001, 3'b000, 3'b000, 3'b100, 3'b010, 3'b001, 3'b100, 3'b010};
  logic       br_tk   [8] = '{1'b0,   1'b1,   1'b1,   1'b0,   1'b1,   1'b0,   1'b1,   1'b0};

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; alu_busy = 1'b0; instr = 16'h0000; status = 3'b000;
    step(); exp_o = idle_o(); cmp_en = 1'b1;
    check("reset_instr_ready", 16'(instr_ready), 16'h0001);
    check("reset_illegal_op",  16'(illegal_op),  16'h0000);
    check("reset_pc_strobes",  16'({cnt_wr_en, pc_inc, wr_en}), 16'h0000);
    step(); rst_n = 1'b1;
    step(); step();

    // ADD op1=01 op2=10 (imm bits [4:3] carry op2)
    run_instr(mk(OP_ADD, 2'b01, 8'h10), 0, 3'b000, 3'b000);
    check("add_rd_sel1", 16'(snap_dec.rd_sel1), 16'h0001);
    check("add_rd_sel2", 16'(snap_dec.rd_sel2), 16'h0002);
    check("add_rd_ens",  16'({snap_dec.rd_en1, snap_dec.rd_en2}), 16'h0003);
    check("add_wr_en",   16'(snap_ret.wr_en),   16'h0001);
    check("add_wr_sel",  16'(snap_ret.wr_sel),  16'h0001);
    check("add_pc_inc",  16'(snap_ret.pc_inc),  16'h0001);

    run_instr(mk(OP_VAL, 2'b11, 8'hA5), 0, 3'b000, 3'b000);
    check("val_sel",    16'(snap_dec.sel),   16'h0000);
    check("val_param",  16'(snap_dec.param), 16'h00A5);
    check("val_no_rd",  16'({snap_dec.rd_en1, snap_dec.rd_en2}), 16'h0000);
    check("val_wr_en",  16'(snap_ret.wr_en),  16'h0001);
    check("val_wr_sel", 16'(snap_ret.wr_sel), 16'h0003);

    run_instr(mk(OP_IFZ, 2'b00, 8'h3F), 0, 3'b000, 3'b001);
    check("ifz_t_cnt", 16'(snap_ret.cnt_wr_en),   16'h0001);
    check("ifz_t_lit", 16'(snap_ret.literal_adr), 16'h003F);
    check("ifz_t_inc", 16'(snap_ret.pc_inc),      16'h0000);
    run_instr(mk(OP_IFZ, 2'b00, 8'h3F), 0, 3'b000, 3'b000);
    check("ifz_n_inc", 16'(snap_ret.pc_inc),    16'h0001);
    check("ifz_n_cnt", 16'(snap_ret.cnt_wr_en), 16'h0000);

    // Stalls: flags toggled during alu_busy must not influence the retire decision
    run_instr(mk(OP_SUB, 2'b10, 8'h08), 3, 3'b111, 3'b000);
    check("sub_stall_wr_en", 16'(snap_ret.wr_en), 16'h0001);
    run_instr(mk(OP_IFZ, 2'b00, 8'h21), 3, 3'b001, 3'b000);
    check("ifz_stall_inc", 16'(snap_ret.pc_inc),    16'h0001);
    check("ifz_stall_cnt", 16'(snap_ret.cnt_wr_en), 16'h0000);

    run_instr(mk(OP_NOT, 2'b01, 8'h18), 1, 3'b000, 3'b000);
    check("not_rd", 16'({snap_dec.rd_en1, snap_dec.rd_sel1, snap_dec.rd_en2, snap_dec.rd_sel2}), 16'h0007);
    run_instr(mk(OP_NOP, 2'b10, 8'h5A), 0, 3'b000, 3'b000);
    check("nop_strobes", 16'({snap_ret.wr_en, snap_ret.cnt_wr_en, snap_ret.pc_inc}), 16'h0001);
    run_instr(mk(OP_GOTO, 2'b00, 8'hC3), 0, 3'b000, 3'b111);
    check("goto_cnt", 16'({snap_ret.cnt_wr_en, snap_ret.pc_inc}), 16'h0002);
    foreach (alu_ops[i]) run_instr(mk(alu_ops[i], 2'(i), 8'h18), i % 2, 3'b010, 3'b100);
    foreach (br_op[i]) begin
      run_instr(mk(br_op[i], 2'b00, 8'h40 + 8'(i)), 0, 3'b000, br_st[i]);
      check("br_taken", 16'(snap_ret.cnt_wr_en), 16'(br_tk[i]));
    end

    // Reserved opcode traps; a later valid GOTO is ignored until reset
    instr = mk(5'b01011, 2'b01, 8'h00); instr_valid = 1'b1;
    step(); exp_o = '0; instr_valid = 1'b0;
    step(); exp_o = '0; exp_o.illegal_op = 1'b1;
    instr = mk(OP_GOTO, 2'b00, 8'h12); instr_valid = 1'b1;
    repeat (4) step();
    check("halt_illegal", 16'(illegal_op),  16'h0001);
    check("halt_ready",   16'(instr_ready), 16'h0000);
    check("halt_no_goto", 16'(cnt_wr_en),   16'h0000);
    instr_valid = 1'b0; rst_n = 1'b0;
    step(); exp_o = idle_o();
    check("halt_reset_illegal", 16'(illegal_op), 16'h0000);
    rst_n = 1'b1;
    step();

    // Reset in EXEC of GOTO suppresses the PC load
    instr = mk(OP_GOTO, 2'b00, 8'h77); instr_valid = 1'b1;
    step(); exp_o = '0; instr_valid = 1'b0;
    step(); exp_o = dec_model(mk(OP_GOTO, 2'b00, 8'h77));
    rst_n = 1'b0;
    step(); exp_o = idle_o();
    check("rst_exec_cnt",   16'(cnt_wr_en),   16'h0000);
    check("rst_exec_ready", 16'(instr_ready), 16'h0001);
    rst_n = 1'b1;
    step();
    check("rst_after_cnt",   16'(cnt_wr_en),   16'h0000);
    check("rst_after_ready", 16'(instr_ready), 16'h0001);
    run_instr(mk(OP_ADD, 2'b11, 8'h08), 0, 3'b000, 3'b000);
    check("post_rst_add_wr", 16'({snap_ret.wr_en, snap_ret.wr_sel}), 16'h0007);

    step();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
